// File: rtl/qrs_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : qrs_pkg
//  Description : Shared types and constants for the QRS detector: detector
//                state encoding and the shift amounts used by the adaptive
//                signal-level / threshold arithmetic.
//  Revision    : 1.0 - initial release
// ============================================================================
package qrs_pkg;

  typedef enum logic [1:0] {
    WARMUP  = 2'd0,
    SEARCH  = 2'd1,
    PEAK    = 2'd2,
    REFRACT = 2'd3
  } qrs_state_e;

  // spk <- spk - (spk >> SPK_SHIFT) + (peak >> SPK_SHIFT)
  localparam int SPK_SHIFT = 3;
  // thr = spk >> THR_SHIFT
  localparam int THR_SHIFT = 1;

endpackage
`default_nettype wire

// File: rtl/qrs_deriv.sv
`default_nettype none
// ============================================================================
//  Module      : qrs_deriv
//  Description : Two-deep sample delay line and absolute two-sample
//                derivative m = |x[n] - x[n-2]|. m is combinational on the
//                incoming sample so the top can act on it at the accept edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module qrs_deriv #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  sample_valid,
  input  logic [DATA_WIDTH-1:0] sample,
  output logic [DATA_WIDTH:0]   m,
  output logic                  m_valid
);

  logic [DATA_WIDTH-1:0] dly1_q;   // x[n-1]
  logic [DATA_WIDTH-1:0] dly2_q;   // x[n-2]
  logic [DATA_WIDTH:0]   w_diff;

  // Shift the delay line on every accepted sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dly1_q <= '0;
      dly2_q <= '0;
    end else if (en && sample_valid) begin
      dly1_q <= sample;
      dly2_q <= dly1_q;
    end
  end

  // Sign-extend to one extra bit so the difference never wraps, then fold.
  always_comb begin
    w_diff = {sample[DATA_WIDTH-1], sample} - {dly2_q[DATA_WIDTH-1], dly2_q};
    m      = w_diff[DATA_WIDTH] ? ('0 - w_diff) : w_diff;
  end

  assign m_valid = en & sample_valid;

endmodule
`default_nettype wire

// File: rtl/qrs_detector.sv
`default_nettype none
// ============================================================================
//  Module      : qrs_detector
//  Description : Streaming QRS detector. Compares the absolute derivative
//                against a threshold, tracks the local peak, emits a one-cycle
//                qrs pulse per beat and then ignores a refractory window.
//                Build option QRS_DETECTOR_ADAPTIVE_EN: when defined, the
//                threshold follows a running signal level (spk); otherwise it
//                is fixed at INIT_THRESHOLD and spk does not exist.
//  Revision    : 1.0 - initial release
// ============================================================================
module qrs_detector
  import qrs_pkg::*;
#(
  parameter int DATA_WIDTH       = 16,
  parameter int INIT_THRESHOLD   = 200,
  parameter int REFRACT_SAMPLES  = 50,
  parameter int MAX_PEAK_SAMPLES = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  sample_valid,
  input  logic [DATA_WIDTH-1:0] sample,
  output logic                  qrs,
  output logic [DATA_WIDTH:0]   peak_level
);

  localparam int c_W    = DATA_WIDTH + 1;
  localparam int c_PK_W = (MAX_PEAK_SAMPLES < 1) ? 1 : $clog2(MAX_PEAK_SAMPLES + 1);
  localparam int c_RF_W = (REFRACT_SAMPLES < 1) ? 1 : $clog2(REFRACT_SAMPLES + 1);
  localparam logic [c_PK_W-1:0] c_PK_MAX  = c_PK_W'(MAX_PEAK_SAMPLES);
  localparam logic [c_PK_W-1:0] c_PK_ONE  = c_PK_W'(1);
  localparam logic [c_RF_W-1:0] c_RF_LOAD = c_RF_W'(REFRACT_SAMPLES);
  localparam logic [c_RF_W-1:0] c_RF_ONE  = c_RF_W'(1);
  // A zero-length refractory window skips straight back to SEARCH.
  localparam qrs_state_e c_POST_PEAK = (REFRACT_SAMPLES == 0) ? SEARCH : REFRACT;

  logic [c_W-1:0]    w_m;
  logic              w_m_valid;
  logic [c_W-1:0]    w_thr;
  logic              w_above;
  logic [c_W-1:0]    w_peak_max;
  logic [c_W-1:0]    w_peak_new;
  logic              w_detect;

  qrs_state_e        state_q, state_d;
  logic              warm_q, warm_d;
  logic [c_PK_W-1:0] pk_cnt_q, pk_cnt_d;
  logic [c_RF_W-1:0] rf_cnt_q, rf_cnt_d;
  logic [c_W-1:0]    peak_q, peak_d;
  logic [c_W-1:0]    peak_level_q, peak_level_d;
  logic              qrs_q;

  qrs_deriv #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_deriv (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .sample_valid (sample_valid),
    .sample       (sample),
    .m            (w_m),
    .m_valid      (w_m_valid)
  );

`ifdef QRS_DETECTOR_ADAPTIVE_EN
  logic [c_W-1:0] spk_q, spk_d;

  assign w_thr = spk_q >> THR_SHIFT;

  // Running signal level: convex blend toward each detected peak.
  always_comb begin
    spk_d = spk_q;
    if (w_detect) begin
      spk_d = spk_q - (spk_q >> SPK_SHIFT) + (w_peak_new >> SPK_SHIFT);
    end
  end

  // Signal-level register, seeded so the first threshold is INIT_THRESHOLD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spk_q <= c_W'(2 * INIT_THRESHOLD);
    end else begin
      spk_q <= spk_d;
    end
  end
`else
  assign w_thr = c_W'(INIT_THRESHOLD);
`endif

  // m == thr is deliberately "not above".
  assign w_above    = (w_m > w_thr);
  assign w_peak_max = (w_m > peak_q) ? w_m : peak_q;
  // Peak value including the terminating sample when it is still above.
  assign w_peak_new = w_above ? w_peak_max : peak_q;

  // Next-state logic; only accepted samples move the detector.
  always_comb begin
    state_d      = state_q;
    warm_d       = warm_q;
    pk_cnt_d     = pk_cnt_q;
    rf_cnt_d     = rf_cnt_q;
    peak_d       = peak_q;
    peak_level_d = peak_level_q;
    w_detect     = 1'b0;
    if (w_m_valid) begin
      unique case (state_q)
        WARMUP: begin
          warm_d = 1'b1;
          if (warm_q) begin
            state_d = SEARCH;
          end
        end
        SEARCH: begin
          if (w_above) begin
            state_d  = PEAK;
            peak_d   = w_m;
            pk_cnt_d = c_PK_ONE;
          end
        end
        PEAK: begin
          if (w_above) begin
            peak_d   = w_peak_max;
            pk_cnt_d = pk_cnt_q + c_PK_ONE;
          end
          if (!w_above || (pk_cnt_q == c_PK_MAX)) begin
            w_detect     = 1'b1;
            peak_level_d = w_peak_new;
            pk_cnt_d     = '0;
            rf_cnt_d     = c_RF_LOAD;
            state_d      = c_POST_PEAK;
          end
        end
        REFRACT: begin
          if (rf_cnt_q != '0) begin
            rf_cnt_d = rf_cnt_q - c_RF_ONE;
          end
          if (rf_cnt_q <= c_RF_ONE) begin
            state_d = SEARCH;
          end
        end
        default: state_d = WARMUP;
      endcase
    end
  end

  // State, counters, peak tracking and the registered detection pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= WARMUP;
      warm_q       <= 1'b0;
      pk_cnt_q     <= '0;
      rf_cnt_q     <= '0;
      peak_q       <= '0;
      peak_level_q <= '0;
      qrs_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      warm_q       <= warm_d;
      pk_cnt_q     <= pk_cnt_d;
      rf_cnt_q     <= rf_cnt_d;
      peak_q       <= peak_d;
      peak_level_q <= peak_level_d;
      qrs_q        <= w_detect;
    end
  end

  assign qrs        = qrs_q;
  assign peak_level = peak_level_q;

endmodule
`default_nettype wire

// File: tb/tb_qrs_detector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_qrs_detector
//  Description : Self-checking bench for qrs_detector. A sample-level model
//                predicts qrs / peak_level on every cycle; directed beats pin
//                the model with hand-computed values, then random traffic runs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_qrs_detector;

  localparam int DW   = 16;
  localparam int INIT = 200;
  localparam int REF  = 50;
  localparam int MAXP = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          sample_valid;
  logic [DW-1:0] sample;
  wire           qrs;
  wire  [DW:0]   peak_level;

  int n_checks   = 0;
  int n_fail     = 0;
  int dut_pulses = 0;

  always #5 clk = ~clk;

  qrs_detector #(
    .DATA_WIDTH       (DW),
    .INIT_THRESHOLD   (INIT),
    .REFRACT_SAMPLES  (REF),
    .MAX_PEAK_SAMPLES (MAXP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .sample_valid (sample_valid),
    .sample       (sample),
    .qrs          (qrs),
    .peak_level   (peak_level)
  );

  // ---------------- behavioural model (per accepted sample) ----------------
  int m_h1 = 0, m_h2 = 0;        // previous two samples
  int m_seen = 0;                // accepted samples since reset (caps at 2)
  int m_in_peak = 0;
  int m_pk_max = 0, m_pk_n = 0;
  int m_refr = 0;                // refractory samples still to ignore
  int m_spk = 2 * INIT;
  bit exp_qrs = 1'b0;
  int exp_peak = 0;
  int mx, mm, mthr;
  bit mfire;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_h1 = 0; m_h2 = 0; m_seen = 0; m_in_peak = 0;
      m_pk_max = 0; m_pk_n = 0; m_refr = 0; m_spk = 2 * INIT;
      exp_qrs = 1'b0; exp_peak = 0;
    end else begin
      exp_qrs = 1'b0;
      if (en && sample_valid) begin
        mx = int'($signed(sample));
        mm = mx - m_h2;
        if (mm < 0) mm = -mm;
`ifdef QRS_DETECTOR_ADAPTIVE_EN
        mthr = m_spk / 2;
`else
        mthr = INIT;
`endif
        if (m_seen < 2) begin
          m_seen++;
        end else if (m_refr > 0) begin
          m_refr--;
        end else if (m_in_peak == 0) begin
          if (mm > mthr) begin
            m_in_peak = 1; m_pk_max = mm; m_pk_n = 1;
          end
        end else begin
          mfire = (mm <= mthr) || (m_pk_n == MAXP);
          if (mm > mthr) begin
            if (mm > m_pk_max) m_pk_max = mm;
            m_pk_n++;
          end
          if (mfire) begin
            exp_qrs   = 1'b1;
            exp_peak  = m_pk_max;
            m_spk     = m_spk - m_spk / 8 + m_pk_max / 8;
            m_in_peak = 0;
            m_refr    = REF;
          end
        end
        m_h2 = m_h1;
        m_h1 = mx;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, half a cycle after the edge.
  always @(negedge clk) begin
    check("qrs", {31'b0, qrs}, {31'b0, exp_qrs});
    check("peak_level", 32'(peak_level), 32'(exp_peak));
    if (qrs === 1'b1) dut_pulses++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input bit v, input int s, input bit e);
    en = e; sample_valid = v; sample = 16'(s);
    @(posedge clk); #2;
  endtask

  task automatic feed(input int s);
    step(1'b1, s, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1; sample_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
  endtask

  initial begin
    int len, a, slope;
    rst = 1'b1; en = 1'b0; sample_valid = 1'b0; sample = '0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    check("reset_qrs", {31'b0, qrs}, 0);
    check("reset_peak_level", 32'(peak_level), 0);

    // Flat input
    repeat (200) feed(0);
    check("flat_pulses", dut_pulses, 0);
    check("flat_peak_level", 32'(peak_level), 0);

    // Single beat: detection right after the edge accepting the 6th sample
    do_reset();
    feed(0); feed(0); feed(0); feed(1000); feed(2000);
    @(negedge clk);
    check("beat_no_early_qrs", {31'b0, qrs}, 0);
    feed(1000);
    @(negedge clk);
    check("beat_qrs_timing", {31'b0, qrs}, 1);
    check("beat_peak_level", 32'(peak_level), 2000);

    // Refractory: beat 20 samples later is ignored, 60 samples later detected
    repeat (19) feed(0);
    feed(1000); feed(2000); feed(1000);
    repeat (38) feed(0);
    check("refract_pulses", dut_pulses, 1);
    feed(1000); feed(2000); feed(1000);
    repeat (5) feed(0);
    check("after_refract_pulses", dut_pulses, 2);
    check("after_refract_peak", 32'(peak_level), 2000);

    // Extreme swing
    do_reset();
    feed(-32768); feed(0); feed(32767); feed(32767); feed(32767);
    repeat (3) feed(0);
    check("extreme_pulses", dut_pulses, 3);
    check("extreme_peak", 32'(peak_level), 65535);

    // m == thr is not above threshold; thr + 1 is
    do_reset();
    feed(0); feed(0); feed(200); feed(200); feed(0); feed(0);
    check("equal_thr_pulses", dut_pulses, 3);
    feed(201); feed(0);
    repeat (3) feed(0);
    check("above_thr_pulses", dut_pulses, 4);
    check("above_thr_peak", 32'(peak_level), 201);

    // Forced end: ramp +500/sample, detection on the 32nd sample in PEAK
    do_reset();
    for (int k = 0; k < 40; k++) begin
      feed(500 * k);
      if (k == 33) begin
        @(negedge clk);
        check("forced_not_yet", {31'b0, qrs}, 0);
      end
      if (k == 34) begin
        @(negedge clk);
        check("forced_qrs", {31'b0, qrs}, 1);
      end
    end
    check("forced_pulses", dut_pulses, 5);
    check("forced_peak", 32'(peak_level), 1000);

    // Reset in PEAK discards the beat; warm-up hides the first two derivatives
    do_reset();
    feed(0); feed(0); feed(0); feed(1000); feed(2000);
    do_reset();
    repeat (12) feed(5000);
    check("reset_peak_pulses", dut_pulses, 5);
    check("reset_peak_level_zero", 32'(peak_level), 0);

    // en low mid-beat freezes everything; beat completes afterwards
    do_reset();
    feed(0); feed(0); feed(0); feed(1000); feed(2000);
    repeat (10) step(1'b1, int'($urandom), 1'b0);
    feed(1000);
    @(negedge clk);
    check("en_resume_qrs", {31'b0, qrs}, 1);
    repeat (5) feed(0);
    check("en_pulses", dut_pulses, 6);
    check("en_peak", 32'(peak_level), 2000);

    // Randomized traffic against the model
    repeat (160) begin
      case ($urandom_range(0, 5))
        0: begin
          len = int'($urandom_range(5, 40));
          repeat (len) step($urandom_range(0, 3) != 0, int'($urandom_range(0, 400)) - 200, 1'b1);
        end
        1: begin
          a = int'($urandom_range(100, 16000));
          feed(0); feed(a / 2); feed(a); feed(a / 2); feed(0);
        end
        2: begin
          slope = int'($urandom_range(50, 400));
          len   = int'($urandom_range(20, 45));
          for (int k = 0; k < len; k++) feed(-8000 + k * slope);
        end
        3: begin
          len = int'($urandom_range(1, 12));
          repeat (len) step(1'($urandom_range(0, 1)), int'($urandom), 1'b0);
        end
        4: if ($urandom_range(0, 3) == 0) do_reset();
        default: begin
          len = int'($urandom_range(1, 6));
          repeat (len) feed(int'($urandom_range(0, 65535)));
        end
      endcase
    end
    repeat (5) step(1'b0, 0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
